// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 800x600@60 timing constants, lock FSM states, saturating helpers
package vga_pkg;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_H_START  = VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_V_START  = VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] val);
    return (val == 12'hFFF) ? val : val + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] val);
    return (val == 11'h7FF) ? val : val + 11'd1;
  endfunction

endpackage

// File: rtl/vga_timing_recover_sync_edge_det.sv
// rtl/vga_timing_recover_sync_edge_det.sv - sync polarity normalise, stage-1 register, leading-edge pulse
module sync_edge_det #(
  parameter bit SYNC_POS = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_edge
);

  logic r_level;
  logic r_level_d;

  // Stage 1: register the sync as active-high, keep the previous stage-1 value for edge detect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level   <= SYNC_POS ? i_sync : ~i_sync;
      r_level_d <= r_level;
    end
  end

  assign o_edge = r_level & ~r_level_d;

endmodule

// File: rtl/vga_timing_recover.sv
// rtl/vga_timing_recover.sv - recovers pixel position, data-enable and lock from a VGA pin stream
module vga_timing_recover
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int H_START  = VGA_H_START,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int V_START  = VGA_V_START,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter bit SYNC_POS = 1'b1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic [11:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic [7:0]  err_cnt
);

  localparam logic [11:0] LP_H_TOT = 12'(H_TOTAL);
  localparam logic [11:0] LP_H_LO  = 12'(H_START);
  localparam logic [11:0] LP_H_HI  = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] LP_V_TOT = 11'(V_TOTAL);
  localparam logic [10:0] LP_V_LO  = 11'(V_START);
  localparam logic [10:0] LP_V_HI  = 11'(V_START + V_ACTIVE);

  logic        w_hedge;
  logic        w_vedge;
  logic [11:0] r_rgb_s1;

  logic [11:0] r_h;
  logic [10:0] r_v;
  lock_state_t r_state;
  logic        r_line_ok;
  logic        r_bad_frame;

  logic [11:0] w_h_nxt;
  logic [10:0] w_v_nxt;
  logic        w_hsat;
  logic        w_line_bad;
  logic        w_lines_bad;
  lock_state_t w_state_nxt;
  logic        w_bad_nxt;
  logic        w_err_inc;
  logic        w_de_nxt;

  sync_edge_det #(.SYNC_POS(SYNC_POS)) u_hs_det (
    .i_clk   (pclk),
    .i_rst_n (rst_n),
    .i_sync  (hs_in),
    .o_edge  (w_hedge)
  );

  sync_edge_det #(.SYNC_POS(SYNC_POS)) u_vs_det (
    .i_clk   (pclk),
    .i_rst_n (rst_n),
    .i_sync  (vs_in),
    .o_edge  (w_vedge)
  );

  // Stage 1 for pixel data so it stays aligned with the registered syncs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_rgb_s1 <= '0;
    else        r_rgb_s1 <= rgb_in;
  end

  // Next counter values, timing checks and lock FSM transitions
  always_comb begin
    w_h_nxt     = w_hedge ? 12'd0 : sat_inc12(r_h);
    w_v_nxt     = w_vedge ? 11'd0 : (w_hedge ? sat_inc11(r_v) : r_v);
    w_hsat      = (w_h_nxt == 12'hFFF);
    // The first hedge after reset closes a partial line, so it is never judged
    w_line_bad  = w_hedge && r_line_ok && (sat_inc12(r_h) != LP_H_TOT);
    w_lines_bad = w_vedge && (sat_inc11(r_v) != LP_V_TOT);
    w_state_nxt = r_state;
    w_bad_nxt   = r_bad_frame;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_bad_nxt = 1'b0;
        if (w_vedge) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_line_bad || w_hsat) w_bad_nxt = 1'b1;
        if (w_vedge) begin
          w_bad_nxt = 1'b0;
          if (!r_bad_frame && !w_line_bad && !w_lines_bad && !w_hsat) w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_line_bad || w_lines_bad || w_hsat) begin
          w_err_inc   = 1'b1;
          w_state_nxt = ST_CHECK;
          // A mid-frame fault spoils the rest of this frame; a fault on vedge starts a clean one
          w_bad_nxt   = !w_vedge;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_bad_nxt   = 1'b0;
      end
    endcase
    w_de_nxt = (w_state_nxt == ST_LOCKED) &&
               (w_h_nxt >= LP_H_LO) && (w_h_nxt < LP_H_HI) &&
               (w_v_nxt >= LP_V_LO) && (w_v_nxt < LP_V_HI);
  end

  // Output stage: counters, FSM, measurements and all outputs update together
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_v         <= '0;
      r_state     <= ST_SEARCH;
      r_line_ok   <= 1'b0;
      r_bad_frame <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      rgb_out     <= '0;
    end else begin
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      r_state     <= w_state_nxt;
      r_bad_frame <= w_bad_nxt;
      if (w_hedge) begin
        r_line_ok <= 1'b1;
        line_len  <= sat_inc12(r_h);
      end
      if (w_vedge) frame_lines <= sat_inc11(r_v);
      if (w_err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      frame_start <= w_vedge;
      locked      <= (w_state_nxt == ST_LOCKED);
      de          <= w_de_nxt;
      x           <= w_de_nxt ? 11'(w_h_nxt - LP_H_LO) : 11'd0;
      y           <= w_de_nxt ? (w_v_nxt - LP_V_LO) : 11'd0;
      rgb_out     <= r_rgb_s1;
    end
  end

endmodule

// File: tb/tb_vga_timing_recover.sv
// tb/tb_vga_timing_recover.sv - directed bench for vga_timing_recover on a reduced video mode
module tb_vga_timing_recover;

  localparam int HT = 24, HSW = 3, HST = 6, HA = 16;
  localparam int VT = 10, VSW = 1, VST = 2, VA = 6;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [11:0] rgb = '0;

  logic [10:0] o_x [2];
  logic [10:0] o_y [2];
  logic        o_de [2];
  logic [11:0] o_rgb [2];
  logic        o_fs [2];
  logic        o_lk [2];
  logic [11:0] o_ll [2];
  logic [10:0] o_fl [2];
  logic [7:0]  o_err [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_vedge_cyc = 0;
  int last_hedge_cyc = 0;

  int de_cnt [2]   = '{0, 0};
  int max_x [2]    = '{0, 0};
  int max_y [2]    = '{0, 0};
  int rgb_bad [2]  = '{0, 0};
  int seq_bad [2]  = '{0, 0};
  int rise_cyc [2] = '{-1, -1};
  int fall_cyc [2] = '{-1, -1};
  int fs_cyc [2]   = '{-1, -1};
  logic        prev_lk [2] = '{1'b0, 1'b0};
  logic        prev_de [2] = '{1'b0, 1'b0};
  logic [10:0] prev_x [2]  = '{11'd0, 11'd0};

  // instance 1: active-high syncs; instance 0: active-low syncs fed the inverted pins
  vga_timing_recover #(
    .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .SYNC_POS(1'b1)
  ) u_pos (
    .pclk(pclk), .rst_n(rst_n), .hs_in(hs), .vs_in(vs), .rgb_in(rgb),
    .x(o_x[1]), .y(o_y[1]), .de(o_de[1]), .rgb_out(o_rgb[1]),
    .frame_start(o_fs[1]), .locked(o_lk[1]), .line_len(o_ll[1]),
    .frame_lines(o_fl[1]), .err_cnt(o_err[1])
  );

  vga_timing_recover #(
    .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA), .SYNC_POS(1'b0)
  ) u_neg (
    .pclk(pclk), .rst_n(rst_n), .hs_in(~hs), .vs_in(~vs), .rgb_in(rgb),
    .x(o_x[0]), .y(o_y[0]), .de(o_de[0]), .rgb_out(o_rgb[0]),
    .frame_start(o_fs[0]), .locked(o_lk[0]), .line_len(o_ll[0]),
    .frame_lines(o_fl[0]), .err_cnt(o_err[0])
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // statistics gathered away from the active edge; tasks compare them
  always @(negedge pclk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_de[k]) begin
        de_cnt[k] <= de_cnt[k] + 1;
        if (int'(o_x[k]) > max_x[k]) max_x[k] <= int'(o_x[k]);
        if (int'(o_y[k]) > max_y[k]) max_y[k] <= int'(o_y[k]);
        if (o_rgb[k] !== {o_x[k][3:0], o_y[k][3:0], 4'h5}) rgb_bad[k] <= rgb_bad[k] + 1;
        if (prev_de[k] && (o_x[k] !== 11'(prev_x[k] + 11'd1))) seq_bad[k] <= seq_bad[k] + 1;
      end
      if (o_lk[k] && !prev_lk[k]) rise_cyc[k] <= cyc;
      if (!o_lk[k] && prev_lk[k]) fall_cyc[k] <= cyc;
      if (o_fs[k]) fs_cyc[k] <= cyc;
      prev_lk[k] <= o_lk[k];
      prev_de[k] <= o_de[k];
      prev_x[k]  <= o_x[k];
    end
  end

  task automatic drive_pix(input int v, input int h);
    @(negedge pclk);
    hs = (h < HSW);
    vs = (v < VSW);
    if (h >= HST && h < HST + HA && v >= VST && v < VST + VA)
      rgb = {4'(h - HST), 4'(v - VST), 4'h5};
    else
      rgb = '0;
    if (h == 0) last_hedge_cyc = cyc;
    if (h == 0 && v == 0) last_vedge_cyc = cyc;
  endtask

  task automatic drive_frame(input int nlines, input int short_v);
    for (int v = 0; v < nlines; v++)
      for (int h = 0; h < ((v == short_v) ? HT - 1 : HT); h++)
        drive_pix(v, h);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      hs = 1'b0;
      vs = 1'b0;
      rgb = '0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle(4);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_x[k], o_y[k], o_de[k], o_rgb[k]} !== '0) begin
        errors++;
        $display("FAIL reset_pixel inst%0d: got x=%0d y=%0d de=%b rgb=%h, want 0", k, o_x[k], o_y[k], o_de[k], o_rgb[k]);
      end
      checks++;
      if ({o_fs[k], o_lk[k]} !== 2'b00) begin
        errors++;
        $display("FAIL reset_flags inst%0d: got fs=%b locked=%b, want 0", k, o_fs[k], o_lk[k]);
      end
      checks++;
      if ({o_ll[k], o_fl[k], o_err[k]} !== '0) begin
        errors++;
        $display("FAIL reset_counts inst%0d: got len=%0d lines=%0d err=%0d, want 0", k, o_ll[k], o_fl[k], o_err[k]);
      end
    end
  endtask

  task automatic test_nominal;
    int snap [2];
    int v2;
    @(negedge pclk);
    rst_n = 1'b1;
    drive_frame(VT, -1);
    snap = de_cnt;
    drive_frame(VT, -1);
    v2 = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rise_cyc[k] != v2 + 2) begin
        errors++;
        $display("FAIL nominal_lock_rise inst%0d: got cycle %0d want %0d", k, rise_cyc[k], v2 + 2);
      end
      checks++;
      if (fs_cyc[k] != v2 + 2) begin
        errors++;
        $display("FAIL nominal_frame_start inst%0d: got cycle %0d want %0d", k, fs_cyc[k], v2 + 2);
      end
      checks++;
      if (de_cnt[k] - snap[k] != HA * VA) begin
        errors++;
        $display("FAIL nominal_de_count inst%0d: got %0d want %0d", k, de_cnt[k] - snap[k], HA * VA);
      end
      checks++;
      if (max_x[k] != HA - 1 || max_y[k] != VA - 1) begin
        errors++;
        $display("FAIL nominal_xy_range inst%0d: got max x=%0d y=%0d want %0d %0d", k, max_x[k], max_y[k], HA - 1, VA - 1);
      end
      checks++;
      if (rgb_bad[k] != 0 || seq_bad[k] != 0) begin
        errors++;
        $display("FAIL nominal_align inst%0d: got rgb_bad=%0d seq_bad=%0d want 0 0", k, rgb_bad[k], seq_bad[k]);
      end
      checks++;
      if (o_ll[k] !== 12'(HT) || o_fl[k] !== 11'(VT) || o_err[k] !== 8'd0) begin
        errors++;
        $display("FAIL nominal_meas inst%0d: got len=%0d lines=%0d err=%0d want %0d %0d 0", k, o_ll[k], o_fl[k], o_err[k], HT, VT);
      end
    end
  endtask

  task automatic test_short_line;
    int s, fc;
    drive_frame(VT, 4);
    s = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fall_cyc[k] != s + 5 * HT - 1 + 2 || o_err[k] !== 8'd1) begin
        errors++;
        $display("FAIL short_line_fall inst%0d: got cycle %0d err=%0d want %0d err=1", k, fall_cyc[k], o_err[k], s + 5 * HT + 1);
      end
    end
    drive_frame(VT, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_lk[k] !== 1'b0) begin
        errors++;
        $display("FAIL short_line_still_unlocked inst%0d: got %b want 0", k, o_lk[k]);
      end
    end
    drive_frame(VT, -1);
    fc = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rise_cyc[k] != fc + 2) begin
        errors++;
        $display("FAIL short_line_relock inst%0d: got cycle %0d want %0d", k, rise_cyc[k], fc + 2);
      end
    end
  endtask

  task automatic test_short_frame;
    int fb, fc;
    drive_frame(VT - 1, -1);
    drive_frame(VT, -1);
    fb = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fall_cyc[k] != fb + 2 || o_lk[k] !== 1'b0) begin
        errors++;
        $display("FAIL short_frame_fall inst%0d: got cycle %0d locked=%b want %0d locked=0", k, fall_cyc[k], o_lk[k], fb + 2);
      end
      checks++;
      if (o_err[k] !== 8'd2 || o_fl[k] !== 11'(VT - 1)) begin
        errors++;
        $display("FAIL short_frame_meas inst%0d: got err=%0d lines=%0d want 2 %0d", k, o_err[k], o_fl[k], VT - 1);
      end
    end
    drive_frame(VT, -1);
    fc = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rise_cyc[k] != fc + 2 || o_fl[k] !== 11'(VT)) begin
        errors++;
        $display("FAIL short_frame_relock inst%0d: got cycle %0d lines=%0d want %0d %0d", k, rise_cyc[k], o_fl[k], fc + 2, VT);
      end
    end
  endtask

  task automatic test_hs_stuck;
    int e, r2;
    int snap [2];
    e = last_hedge_cyc;
    snap = de_cnt;
    drive_idle(5000);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fall_cyc[k] != e + 2 + 4095) begin
        errors++;
        $display("FAIL stuck_sat_fall inst%0d: got cycle %0d want %0d", k, fall_cyc[k], e + 4097);
      end
      checks++;
      if (o_err[k] !== 8'd3 || o_de[k] !== 1'b0 || de_cnt[k] != snap[k]) begin
        errors++;
        $display("FAIL stuck_state inst%0d: got err=%0d de=%b de_cycles=%0d want 3 0 0", k, o_err[k], o_de[k], de_cnt[k] - snap[k]);
      end
    end
    drive_frame(VT, -1);
    drive_frame(VT, -1);
    r2 = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rise_cyc[k] != r2 + 2) begin
        errors++;
        $display("FAIL stuck_relock inst%0d: got cycle %0d want %0d", k, rise_cyc[k], r2 + 2);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n2;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        drive_pix(v, h);
        if (v == 4 && h == 10) begin
          #1 rst_n = 1'b0;
          #1;
          for (int k = 0; k < 2; k++) begin
            checks++;
            if ({o_x[k], o_y[k], o_de[k], o_rgb[k], o_fs[k], o_lk[k]} !== '0) begin
              errors++;
              $display("FAIL midreset_pixel inst%0d: got x=%0d y=%0d de=%b rgb=%h locked=%b want 0", k, o_x[k], o_y[k], o_de[k], o_rgb[k], o_lk[k]);
            end
            checks++;
            if ({o_ll[k], o_fl[k], o_err[k]} !== '0) begin
              errors++;
              $display("FAIL midreset_counts inst%0d: got len=%0d lines=%0d err=%0d want 0", k, o_ll[k], o_fl[k], o_err[k]);
            end
          end
        end
        if (v == 4 && h == 13) #1 rst_n = 1'b1;
      end
    end
    drive_frame(VT, -1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_fl[k] !== 11'd6 || o_lk[k] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_partial inst%0d: got lines=%0d locked=%b want 6 0", k, o_fl[k], o_lk[k]);
      end
    end
    drive_frame(VT, -1);
    n2 = last_vedge_cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rise_cyc[k] != n2 + 2 || fs_cyc[k] != n2 + 2) begin
        errors++;
        $display("FAIL midreset_relock inst%0d: got rise=%0d fs=%0d want %0d", k, rise_cyc[k], fs_cyc[k], n2 + 2);
      end
      checks++;
      if (o_fl[k] !== 11'(VT) || o_ll[k] !== 12'(HT) || o_err[k] !== 8'd0) begin
        errors++;
        $display("FAIL midreset_meas inst%0d: got lines=%0d len=%0d err=%0d want %0d %0d 0", k, o_fl[k], o_ll[k], o_err[k], VT, HT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_short_line;
    test_short_frame;
    test_hs_stuck;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
